// File: rtl/jtframe_sdram_pkg.sv
// Shared types and helpers for the CPU-side SDRAM slot requesters.
package jtframe_sdram_pkg;

   localparam int SDRAM_AW = 22;
   localparam int LINE_W   = 32;
   localparam int WMASK_W  = 2;
   localparam int TAG_W    = SDRAM_AW - 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE,
      ST_ABORT
   } rqc_state_e;

   // Select the CPU-visible data from a 32-bit line. In byte mode the byte
   // lands in bits 7:0 so the caller can simply truncate to its data width.
   function automatic logic [15:0] line_pick(input logic [LINE_W-1:0] line,
                                             input logic              wsel,
                                             input logic              bsel,
                                             input logic              byte_mode);
      logic [15:0] word;
      word = wsel ? line[31:16] : line[15:0];
      if (byte_mode)
         return {8'h00, (bsel ? word[15:8] : word[7:0])};
      return word;
   endfunction

endpackage

// File: rtl/jtframe_ram_rqc_line.sv
// One-line read cache: tag, valid bit and 32-bit data with a byte-merge port.
module jtframe_ram_rqc_line
   import jtframe_sdram_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              load_i,
   input  logic [LINE_W-1:0] load_data_i,
   input  logic              wr_i,
   input  logic [3:0]        wr_be_i,
   input  logic [LINE_W-1:0] wr_data_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic [TAG_W-1:0]  chk_tag_i,
   output logic              hit_o,
   output logic [LINE_W-1:0] data_o
);

   logic              valid_q;
   logic [TAG_W-1:0]  tag_q;
   logic [LINE_W-1:0] data_q;
   logic              merge_w;

   assign hit_o   = valid_q && (tag_q == chk_tag_i);
   assign merge_w = wr_i && valid_q && (tag_q == tag_i);
   assign data_o  = data_q;

   // Flush beats a fill so a line returned during flush is never kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else begin
         if (flush_i) begin
            valid_q <= 1'b0;
         end else if (load_i) begin
            valid_q <= 1'b1;
            tag_q   <= tag_i;
            data_q  <= load_data_i;
         end
         if (merge_w) begin
            for (int b = 0; b < 4; b++) begin
               if (wr_be_i[b])
                  data_q[b*8 +: 8] <= wr_data_i[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/jtframe_ram_rqc.sv
// CPU-side SDRAM slot requester with 8/16-bit data, byte masks, a one-line
// read cache, abort-safe completion and one queued back-to-back request.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_IDLE  | no access in flight; waits for cs rising edge or pending
//  ST_REQ   | req raised, waiting for the arbiter to take it (we)
//  ST_WAIT  | request taken, waiting for din_ok
//  ST_DONE  | data_ok high, waiting for cs to fall
//  ST_ABORT | CPU dropped cs mid-access; finish SDRAM side silently
module jtframe_ram_rqc
   import jtframe_sdram_pkg::*;
#(
   parameter int AW    = 18,
   parameter int DW    = 8,
   parameter int CACHE = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [AW-1:0]       addr,
   input  logic [SDRAM_AW-1:0] offset,
   input  logic                cs,
   input  logic                wrin,
   input  logic [DW-1:0]       wrdata,
   input  logic                flush,
   input  logic                we,
   input  logic [LINE_W-1:0]   din,
   input  logic                din_ok,
   output logic                req,
   output logic                req_rnw,
   output logic [SDRAM_AW-1:0] sdram_addr,
   output logic [15:0]         sdram_din,
   output logic [WMASK_W-1:0]  sdram_wmask,
   output logic [DW-1:0]       dout,
   output logic                data_ok
);

   localparam logic BYTE_MODE = (DW == 8);

   if (DW != 8 && DW != 16) begin : g_bad_dw
      $error("jtframe_ram_rqc: DW must be 8 or 16");
   end

   rqc_state_e          state_q;
   logic                cs_q;
   logic                pend_q;
   logic                pend_wr_q;
   logic [AW-1:0]       pend_addr_q;
   logic [DW-1:0]       pend_data_q;
   logic                wsel_q;
   logic                bsel_q;
   logic                is_wr_q;
   logic                req_q;
   logic                req_rnw_q;
   logic                data_ok_q;
   logic [SDRAM_AW-1:0] sdram_addr_q;
   logic [15:0]         sdram_din_q;
   logic [WMASK_W-1:0]  wmask_q;
   logic [DW-1:0]       dout_q;

   logic                cs_rise_w;
   logic [AW-1:0]       src_addr_w;
   logic                src_wr_w;
   logic [DW-1:0]       src_data_w;
   logic [SDRAM_AW-1:0] addr_ext_w;
   logic [SDRAM_AW-1:0] wa_d;
   logic [SDRAM_AW-1:0] la_d;
   logic                bsel_d;
   logic [15:0]         wdata_d;
   logic [WMASK_W-1:0]  wmask_d;
   logic                go_w;
   logic                hit_w;
   logic                rd_hit_w;
   logic                cmp_w;
   logic [LINE_W-1:0]   line_w;
   logic [3:0]          line_be_w;

   assign cs_rise_w = cs && !cs_q;

   // A queued request takes precedence over the live CPU bus.
   assign src_addr_w = pend_q ? pend_addr_q : addr;
   assign src_wr_w   = pend_q ? pend_wr_q   : wrin;
   assign src_data_w = pend_q ? pend_data_q : wrdata;

   assign addr_ext_w = SDRAM_AW'(src_addr_w);
   assign wa_d       = (BYTE_MODE ? (addr_ext_w >> 1) : addr_ext_w) + offset;
   assign la_d       = {wa_d[SDRAM_AW-1:1], 1'b0};
   assign bsel_d     = BYTE_MODE && src_addr_w[0];
   assign wdata_d    = BYTE_MODE ? {2{src_data_w[7:0]}} : 16'(src_data_w);
   assign wmask_d    = BYTE_MODE ? (bsel_d ? 2'b10 : 2'b01) : 2'b11;

   assign go_w     = (state_q == ST_IDLE) && (cs_rise_w || pend_q);
   assign rd_hit_w = (CACHE != 0) && hit_w && !flush && !src_wr_w;

   // din_ok only counts when the slot holds a taken (or just-taken) request.
   always_comb begin
      cmp_w = 1'b0;
      case (state_q)
         ST_REQ:   cmp_w = we && din_ok;
         ST_WAIT:  cmp_w = din_ok;
         ST_ABORT: cmp_w = din_ok && (we || !req_q);
         default:  cmp_w = 1'b0;
      endcase
   end

   assign line_be_w = wsel_q ? {wmask_q, 2'b00} : {2'b00, wmask_q};

   jtframe_ram_rqc_line u_line (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (flush),
      .load_i      (cmp_w && !is_wr_q),
      .load_data_i (din),
      .wr_i        (cmp_w && is_wr_q),
      .wr_be_i     (line_be_w),
      .wr_data_i   ({sdram_din_q, sdram_din_q}),
      .tag_i       (sdram_addr_q[SDRAM_AW-1:1]),
      .chk_tag_i   (wa_d[SDRAM_AW-1:1]),
      .hit_o       (hit_w),
      .data_o      (line_w)
   );

   // Request FSM with registered outputs; completion handling after the case
   // overrides the per-state next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cs_q         <= 1'b0;
         pend_q       <= 1'b0;
         pend_wr_q    <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         wsel_q       <= 1'b0;
         bsel_q       <= 1'b0;
         is_wr_q      <= 1'b0;
         req_q        <= 1'b0;
         req_rnw_q    <= 1'b1;
         data_ok_q    <= 1'b0;
         sdram_addr_q <= '0;
         sdram_din_q  <= '0;
         wmask_q      <= '0;
         dout_q       <= '0;
      end else begin
         cs_q <= cs;

         if ((state_q == ST_ABORT || state_q == ST_DONE) && cs_rise_w) begin
            pend_q      <= 1'b1;
            pend_addr_q <= addr;
            pend_wr_q   <= wrin;
            pend_data_q <= wrdata;
         end

         case (state_q)
            ST_IDLE: begin
               if (go_w) begin
                  pend_q <= 1'b0;
                  wsel_q <= wa_d[0];
                  bsel_q <= bsel_d;
                  if (rd_hit_w) begin
                     dout_q    <= DW'(line_pick(line_w, wa_d[0], bsel_d, BYTE_MODE));
                     data_ok_q <= 1'b1;
                     state_q   <= ST_DONE;
                  end else begin
                     req_q        <= 1'b1;
                     req_rnw_q    <= !src_wr_w;
                     is_wr_q      <= src_wr_w;
                     sdram_addr_q <= src_wr_w ? wa_d : la_d;
                     wmask_q      <= src_wr_w ? wmask_d : 2'b00;
                     if (src_wr_w)
                        sdram_din_q <= wdata_d;
                     state_q <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (we)
                  req_q <= 1'b0;
               if (!cs)
                  state_q <= ST_ABORT;
               else if (we)
                  state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!cs)
                  state_q <= ST_ABORT;
            end
            ST_ABORT: begin
               if (we)
                  req_q <= 1'b0;
            end
            ST_DONE: begin
               if (!cs) begin
                  data_ok_q <= 1'b0;
                  state_q   <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         if (cmp_w) begin
            req_rnw_q <= 1'b1;
            if (state_q != ST_ABORT && cs) begin
               data_ok_q <= 1'b1;
               if (!is_wr_q)
                  dout_q <= DW'(line_pick(din, wsel_q, bsel_q, BYTE_MODE));
               state_q <= ST_DONE;
            end else begin
               state_q <= ST_IDLE;
            end
         end
      end
   end

   assign req         = req_q;
   assign req_rnw     = req_rnw_q;
   assign sdram_addr  = sdram_addr_q;
   assign sdram_din   = sdram_din_q;
   assign sdram_wmask = wmask_q;
   assign dout        = dout_q;
   assign data_ok     = data_ok_q;

endmodule

// File: tb/tb_jtframe_ram_rqc.sv
// Directed bench for jtframe_ram_rqc (AW=18, DW=8, CACHE=1, offset 0x1000).
module tb_jtframe_ram_rqc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [17:0] addr;
   logic [21:0] offset;
   logic        cs;
   logic        wrin;
   logic [7:0]  wrdata;
   logic        flush;
   logic        we;
   logic [31:0] din;
   logic        din_ok;
   logic        req;
   logic        req_rnw;
   logic [21:0] sdram_addr;
   logic [15:0] sdram_din;
   logic [1:0]  sdram_wmask;
   logic [7:0]  dout;
   logic        data_ok;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   jtframe_ram_rqc #(.AW(18), .DW(8), .CACHE(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .addr        (addr),
      .offset      (offset),
      .cs          (cs),
      .wrin        (wrin),
      .wrdata      (wrdata),
      .flush       (flush),
      .we          (we),
      .din         (din),
      .din_ok      (din_ok),
      .req         (req),
      .req_rnw     (req_rnw),
      .sdram_addr  (sdram_addr),
      .sdram_din   (sdram_din),
      .sdram_wmask (sdram_wmask),
      .dout        (dout),
      .data_ok     (data_ok)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Read expected to hit the line: data_ok one cycle after cs, no req.
   task automatic hit_read(input logic [17:0] a, input logic [7:0] exp, input string tag);
      addr = a;
      wrin = 1'b0;
      cs   = 1'b1;
      step();
      check({tag, "_req"},  {31'd0, req},     32'd0);
      check({tag, "_ok"},   {31'd0, data_ok}, 32'd1);
      check({tag, "_dout"}, {24'd0, dout},    {24'd0, exp});
      cs = 1'b0;
      step();
      check({tag, "_okclr"}, {31'd0, data_ok}, 32'd0);
   endtask

   initial begin
      rst_n  = 1'b0;
      addr   = '0;
      offset = 22'h1000;
      cs     = 1'b0;
      wrin   = 1'b0;
      wrdata = '0;
      flush  = 1'b0;
      we     = 1'b0;
      din    = '0;
      din_ok = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req",   {31'd0, req},        32'd0);
      check("rst_rnw",   {31'd0, req_rnw},    32'd1);
      check("rst_ok",    {31'd0, data_ok},    32'd0);
      check("rst_dout",  {24'd0, dout},       32'd0);
      check("rst_addr",  {10'd0, sdram_addr}, 32'd0);
      check("rst_sdin",  {16'd0, sdram_din},  32'd0);
      check("rst_wmask", {30'd0, sdram_wmask}, 32'd0);
      rst_n = 1'b1;
      step();

      // Read miss: addr 5 -> word 0x1002 (even), byte lane 1 of word 0.
      addr = 18'h5;
      cs   = 1'b1;
      step();
      check("miss_req",  {31'd0, req},        32'd1);
      check("miss_rnw",  {31'd0, req_rnw},    32'd1);
      check("miss_addr", {10'd0, sdram_addr}, 32'h1002);
      we     = 1'b1;
      din_ok = 1'b1;
      din    = 32'hDDCC_BBAA;
      step();
      check("miss_ok",   {31'd0, data_ok}, 32'd1);
      check("miss_dout", {24'd0, dout},    32'hBB);
      check("miss_reqclr", {31'd0, req},   32'd0);
      we     = 1'b0;
      din_ok = 1'b0;
      cs     = 1'b0;
      step();
      check("miss_okclr", {31'd0, data_ok}, 32'd0);

      // Hits on the same line: addr 7 -> word 1 high, 6 -> word 1 low, 4 -> word 0 low.
      hit_read(18'h7, 8'hDD, "hit7");
      hit_read(18'h6, 8'hCC, "hit6");
      hit_read(18'h4, 8'hAA, "hit4");

      // Byte write to addr 5: word 0x1002, upper lane, byte replicated.
      addr   = 18'h5;
      wrin   = 1'b1;
      wrdata = 8'h5A;
      cs     = 1'b1;
      step();
      check("wr_req",   {31'd0, req},         32'd1);
      check("wr_rnw",   {31'd0, req_rnw},     32'd0);
      check("wr_addr",  {10'd0, sdram_addr},  32'h1002);
      check("wr_sdin",  {16'd0, sdram_din},   32'h5A5A);
      check("wr_wmask", {30'd0, sdram_wmask}, 32'h2);
      we = 1'b1;
      step();
      check("wr_taken", {31'd0, req},     32'd0);
      check("wr_wait",  {31'd0, data_ok}, 32'd0);
      we     = 1'b0;
      din_ok = 1'b1;
      step();
      check("wr_ok",     {31'd0, data_ok}, 32'd1);
      check("wr_rnwset", {31'd0, req_rnw}, 32'd1);
      din_ok = 1'b0;
      cs     = 1'b0;
      wrin   = 1'b0;
      step();
      hit_read(18'h5, 8'h5A, "merge5");
      hit_read(18'h4, 8'hAA, "merge4");

      // Abort: cs drops before the arbiter takes the request.
      addr = 18'h21;
      cs   = 1'b1;
      step();
      check("ab_req", {31'd0, req}, 32'd1);
      check("ab_addr", {10'd0, sdram_addr}, 32'h1010);
      cs = 1'b0;
      step();
      check("ab_hold", {31'd0, req},     32'd1);
      check("ab_nook", {31'd0, data_ok}, 32'd0);
      we     = 1'b1;
      din_ok = 1'b1;
      din    = 32'h4433_2211;
      step();
      check("ab_reqclr", {31'd0, req},     32'd0);
      check("ab_noclr",  {31'd0, data_ok}, 32'd0);
      check("ab_dout",   {24'd0, dout},    32'hAA);
      we     = 1'b0;
      din_ok = 1'b0;
      step();
      check("ab_idle", {31'd0, data_ok}, 32'd0);
      hit_read(18'h21, 8'h22, "abfill21");
      hit_read(18'h23, 8'h44, "abfill23");

      // Back-to-back: second cs rises during ABORT and is queued.
      addr = 18'h41;
      cs   = 1'b1;
      step();
      check("b2b_req1", {31'd0, req}, 32'd1);
      cs = 1'b0;
      step();
      check("b2b_hold", {31'd0, req}, 32'd1);
      addr   = 18'h61;
      wrin   = 1'b1;
      wrdata = 8'h77;
      cs     = 1'b1;
      step();
      check("b2b_stillab", {31'd0, req}, 32'd1);
      addr   = 18'h0;
      wrin   = 1'b0;
      wrdata = 8'h00;
      we     = 1'b1;
      din_ok = 1'b1;
      din    = 32'h8877_6655;
      step();
      check("b2b_exit_req", {31'd0, req},     32'd0);
      check("b2b_exit_ok",  {31'd0, data_ok}, 32'd0);
      we     = 1'b0;
      din_ok = 1'b0;
      step();
      check("b2b_req2",  {31'd0, req},         32'd1);
      check("b2b_rnw2",  {31'd0, req_rnw},     32'd0);
      check("b2b_addr2", {10'd0, sdram_addr},  32'h1030);
      check("b2b_sdin2", {16'd0, sdram_din},   32'h7777);
      check("b2b_mask2", {30'd0, sdram_wmask}, 32'h2);
      we     = 1'b1;
      din_ok = 1'b1;
      step();
      check("b2b_ok2",     {31'd0, data_ok}, 32'd1);
      check("b2b_reqclr2", {31'd0, req},     32'd0);
      we     = 1'b0;
      din_ok = 1'b0;
      cs     = 1'b0;
      step();
      hit_read(18'h41, 8'h66, "b2bfill");

      // Flush on a hit-eligible read forces a miss.
      addr  = 18'h41;
      flush = 1'b1;
      cs    = 1'b1;
      step();
      check("fl_req",  {31'd0, req},        32'd1);
      check("fl_addr", {10'd0, sdram_addr}, 32'h1020);
      check("fl_nook", {31'd0, data_ok},    32'd0);
      flush = 1'b0;
      we    = 1'b1;
      step();
      check("fl_taken", {31'd0, req}, 32'd0);
      we = 1'b0;

      // Reset while waiting for din_ok; late din_ok must be ignored.
      rst_n = 1'b0;
      cs    = 1'b0;
      #1;
      check("mr_req",  {31'd0, req},     32'd0);
      check("mr_ok",   {31'd0, data_ok}, 32'd0);
      check("mr_rnw",  {31'd0, req_rnw}, 32'd1);
      check("mr_dout", {24'd0, dout},    32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      din_ok = 1'b1;
      din    = 32'hFFFF_FFFF;
      step();
      check("late_req",  {31'd0, req},     32'd0);
      check("late_ok",   {31'd0, data_ok}, 32'd0);
      check("late_dout", {24'd0, dout},    32'd0);
      din_ok = 1'b0;
      step();
      addr = 18'h41;
      cs   = 1'b1;
      step();
      check("post_rst_miss", {31'd0, req}, 32'd1);
      cs = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
